// File: rtl/seq_alu.sv
// Clocked ALU: add/sub/logic in 1 cycle; iterative shift-add multiply and restoring divide in WIDTH+1 cycles.
// One operation in flight; result and flags are held in DONE until out_ready, and in_ready is high only in IDLE.
module seq_alu #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] firstInput,
   input  logic [WIDTH-1:0] secondInput,
   input  logic [3:0]       operation,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_Out,
   output logic [WIDTH-1:0] ALU_OutHi,
   output logic             CarryOut,
   output logic             Overflow,
   output logic             Zero,
   output logic             DivByZero
);
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b1000;
   localparam logic [3:0] OP_OR  = 4'b1001;
   localparam logic [3:0] OP_XOR = 4'b1010;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hi_q, lo_q, b_q;

   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] sc_res;
   logic             sc_c, sc_v;

   logic [WIDTH:0]   mul_sum, div_shift;
   logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt, div_rem_nxt, div_quo_nxt, div_diff;
   logic             div_ge;

   assign in_ready = (state == S_IDLE);

   always_comb begin
      sum    = {1'b0, firstInput} + {1'b0, secondInput};
      diff   = {1'b0, firstInput} - {1'b0, secondInput};
      sc_res = sum[WIDTH-1:0];
      sc_c   = sum[WIDTH];
      sc_v   = (firstInput[WIDTH-1] == secondInput[WIDTH-1]) &&
               (sum[WIDTH-1] != firstInput[WIDTH-1]);
      case (operation)
         OP_SUB: begin
            sc_res = diff[WIDTH-1:0];
            sc_c   = diff[WIDTH];
            sc_v   = (firstInput[WIDTH-1] != secondInput[WIDTH-1]) &&
                     (diff[WIDTH-1] != firstInput[WIDTH-1]);
         end
         OP_AND: begin sc_res = firstInput & secondInput; sc_c = 1'b0; sc_v = 1'b0; end
         OP_OR:  begin sc_res = firstInput | secondInput; sc_c = 1'b0; sc_v = 1'b0; end
         OP_XOR: begin sc_res = firstInput ^ secondInput; sc_c = 1'b0; sc_v = 1'b0; end
         default: ;
      endcase
   end

   // hi_q is the running high half (MUL) or partial remainder (DIV); lo_q holds multiplier/quotient bits.
   always_comb begin
      mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      mul_hi_nxt  = mul_sum[WIDTH:1];
      mul_lo_nxt  = {mul_sum[0], lo_q[WIDTH-1:1]};
      div_shift   = {hi_q, lo_q[WIDTH-1]};
      div_ge      = (div_shift >= {1'b0, b_q});
      div_diff    = div_shift[WIDTH-1:0] - b_q;
      div_rem_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
      div_quo_nxt = {lo_q[WIDTH-2:0], div_ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         b_q       <= '0;
         out_valid <= 1'b0;
         ALU_Out   <= '0;
         ALU_OutHi <= '0;
         CarryOut  <= 1'b0;
         Overflow  <= 1'b0;
         Zero      <= 1'b0;
         DivByZero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  b_q  <= secondInput;
                  hi_q <= '0;
                  lo_q <= firstInput;
                  cnt  <= CW'(WIDTH - 1);
                  if (operation == OP_MUL) begin
                     state <= S_MUL;
                  end else if (operation == OP_DIV) begin
                     state <= S_DIV;
                  end else begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                     ALU_Out   <= sc_res;
                     ALU_OutHi <= '0;
                     CarryOut  <= sc_c;
                     Overflow  <= sc_v;
                     Zero      <= (sc_res == '0);
                     DivByZero <= 1'b0;
                  end
               end
            end
            S_MUL: begin
               hi_q <= mul_hi_nxt;
               lo_q <= mul_lo_nxt;
               cnt  <= cnt - 1'b1;
               if (cnt == '0) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  ALU_Out   <= mul_lo_nxt;
                  ALU_OutHi <= mul_hi_nxt;
                  CarryOut  <= 1'b0;
                  Overflow  <= 1'b0;
                  Zero      <= (mul_lo_nxt == '0);
                  DivByZero <= 1'b0;
               end
            end
            S_DIV: begin
               // B==0 needs no special path: every step "fits", giving all-ones quotient and remainder A.
               hi_q <= div_rem_nxt;
               lo_q <= div_quo_nxt;
               cnt  <= cnt - 1'b1;
               if (cnt == '0) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  ALU_Out   <= div_quo_nxt;
                  ALU_OutHi <= div_rem_nxt;
                  CarryOut  <= 1'b0;
                  Overflow  <= 1'b0;
                  Zero      <= (div_quo_nxt == '0);
                  DivByZero <= (b_q == '0);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
